// File: rtl/daisy_chain_master.sv
// daisy_chain_master
//
// SPI master for a daisy chain of CHAIN_LEN store-and-forward slaves. One
// DATA_W-bit frame is shifted LSB-first into the first slave. Clocking
// continues until that frame has passed through every slave and come back on
// miso, which is then presented on dout together with a one-cycle done pulse.
//
// Optional feature macro: DAISY_LOOPBACK_CHECK_EN
//   defined   : in DONE, mismatch = (returned frame != frame sent), held
//               until the next DONE or reset.
//   undefined : compare logic is absent and mismatch is tied to 0.
//
// Ports
//   clk      in   system clock, all logic on the rising edge
//   rst_n    in   synchronous active-low reset
//   start    in   transfer request, accepted only in IDLE
//   din      in   frame to send, latched on the accepting cycle
//   miso     in   sdo of the last slave in the chain
//   sclk     out  serial clock, idles low
//   cs       out  chip select, active low
//   newd     out  new-data qualifier, high while cs is low
//   mosi     out  serial data to the first slave
//   busy     out  high from the accepting cycle until DONE ends
//   done     out  one-cycle pulse, dout valid
//   dout     out  frame returned through the chain
//   mismatch out  loopback compare result (see macro above)
module daisy_chain_master #(
    parameter int CHAIN_LEN = 2,
    parameter int CLK_DIV   = 4,
    parameter int DATA_W    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] din,
    input  logic              miso,
    output logic              sclk,
    output logic              cs,
    output logic              newd,
    output logic              mosi,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] dout,
    output logic              mismatch
);

    // Each slave delays the frame by DATA_W+1 edges; the last DATA_W periods
    // bring the frame itself back out of the chain.
    localparam int N_PER = (DATA_W + 1) * CHAIN_LEN + DATA_W;
    localparam int PER_W = $clog2(N_PER);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [PER_W-1:0] LAST_PER = PER_W'(N_PER - 1);
    localparam logic [DIV_W-1:0] LAST_DIV = DIV_W'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state, state_n;
    logic [DIV_W-1:0]  div_cnt, div_n;
    logic [PER_W-1:0]  per_cnt, per_n;
    logic [DATA_W-1:0] tx_sr, tx_n;
    logic [DATA_W-1:0] rx_sr, rx_n;
    logic [DATA_W:0]   rx_cat;
    logic [DATA_W-1:0] tx_shift;
    logic              sclk_n, cs_n, newd_n, mosi_n, busy_n, done_n;
    logic [DATA_W-1:0] dout_n;

`ifdef DAISY_LOOPBACK_CHECK_EN
    logic [DATA_W-1:0] din_lat, din_lat_n;
    logic              mismatch_n;
`else
    assign mismatch = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            div_cnt  <= '0;
            per_cnt  <= '0;
            tx_sr    <= '0;
            rx_sr    <= '0;
            sclk     <= 1'b0;
            cs       <= 1'b1;
            newd     <= 1'b0;
            mosi     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            dout     <= '0;
`ifdef DAISY_LOOPBACK_CHECK_EN
            din_lat  <= '0;
            mismatch <= 1'b0;
`endif
        end else begin
            state    <= state_n;
            div_cnt  <= div_n;
            per_cnt  <= per_n;
            tx_sr    <= tx_n;
            rx_sr    <= rx_n;
            sclk     <= sclk_n;
            cs       <= cs_n;
            newd     <= newd_n;
            mosi     <= mosi_n;
            busy     <= busy_n;
            done     <= done_n;
            dout     <= dout_n;
`ifdef DAISY_LOOPBACK_CHECK_EN
            din_lat  <= din_lat_n;
            mismatch <= mismatch_n;
`endif
        end
    end

    // All outputs are registered: the combinational process computes the
    // value each output takes in the next cycle.
    always_comb begin
        state_n  = state;
        div_n    = div_cnt;
        per_n    = per_cnt;
        tx_n     = tx_sr;
        rx_n     = rx_sr;
        sclk_n   = sclk;
        cs_n     = cs;
        newd_n   = newd;
        mosi_n   = mosi;
        busy_n   = busy;
        done_n   = 1'b0;
        dout_n   = dout;
        // Incoming bit enters at the MSB; the frame drifts toward bit 0.
        rx_cat   = {miso, rx_sr};
        // tx_sr[0] is always the bit currently on mosi; zeros fill behind it
        // so mosi is 0 once the frame has been sent.
        tx_shift = tx_sr >> 1;
`ifdef DAISY_LOOPBACK_CHECK_EN
        din_lat_n  = din_lat;
        mismatch_n = mismatch;
`endif

        unique case (state)
            IDLE: begin
                if (start) begin
                    state_n = SETUP;
                    busy_n  = 1'b1;
                    cs_n    = 1'b0;
                    newd_n  = 1'b1;
                    sclk_n  = 1'b0;
                    mosi_n  = din[0];
                    tx_n    = din;
                    div_n   = '0;
                    per_n   = '0;
`ifdef DAISY_LOOPBACK_CHECK_EN
                    din_lat_n = din;
`endif
                end
            end

            SETUP: begin
                if (div_cnt == LAST_DIV) begin
                    // Rising edge of period 0: din[0] is already on mosi.
                    state_n = SHIFT;
                    div_n   = '0;
                    sclk_n  = 1'b1;
                end else begin
                    div_n = div_cnt + 1'b1;
                end
            end

            SHIFT: begin
                if (div_cnt != LAST_DIV) begin
                    div_n = div_cnt + 1'b1;
                end else begin
                    div_n = '0;
                    if (sclk) begin
                        // Falling edge: sample miso as it is before the edge.
                        sclk_n = 1'b0;
                        rx_n   = rx_cat[DATA_W:1];
                    end else if (per_cnt == LAST_PER) begin
                        state_n = DONE;
                        cs_n    = 1'b1;
                        newd_n  = 1'b0;
                        mosi_n  = 1'b0;
                        done_n  = 1'b1;
                        dout_n  = rx_sr;
`ifdef DAISY_LOOPBACK_CHECK_EN
                        mismatch_n = (rx_sr != din_lat);
`endif
                    end else begin
                        // Rising edge of the next period: advance mosi.
                        per_n  = per_cnt + 1'b1;
                        sclk_n = 1'b1;
                        tx_n   = tx_shift;
                        mosi_n = tx_shift[0];
                    end
                end
            end

            DONE: begin
                state_n = IDLE;
                busy_n  = 1'b0;
            end

            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_daisy_chain_master.sv
// Self-checking bench for daisy_chain_master.
// Environment: a behavioural chain of identity store-and-forward slaves
// (each adds a DATA_W+1 falling-edge delay) or miso tied high.
// Reference model: a transfer is accepted when start is high on an edge at or
// after the earliest idle edge; expected dout, mismatch, done time, sclk count
// and mosi sequence are pushed into a queue and checked when done pulses.
module tb_daisy_chain_master;

    localparam int CHAIN_LEN = 2;
    localparam int CLK_DIV   = 2;
    localparam int DATA_W    = 8;
    localparam int N_PER     = (DATA_W + 1) * CHAIN_LEN + DATA_W;
    localparam int DELAY     = (DATA_W + 1) * CHAIN_LEN;
    localparam int LAT       = CLK_DIV + 2 * CLK_DIV * N_PER;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [DATA_W-1:0] din;
    logic              miso;
    logic              sclk, cs, newd, mosi, busy, done, mismatch;
    logic [DATA_W-1:0] dout;

    daisy_chain_master #(
        .CHAIN_LEN(CHAIN_LEN),
        .CLK_DIV  (CLK_DIV),
        .DATA_W   (DATA_W)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .din     (din),
        .miso    (miso),
        .sclk    (sclk),
        .cs      (cs),
        .newd    (newd),
        .mosi    (mosi),
        .busy    (busy),
        .done    (done),
        .dout    (dout),
        .mismatch(mismatch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [DATA_W-1:0] din;
        logic [DATA_W-1:0] dout;
        logic              mm;
        int                t_done;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc      = 0;
    int   next_free = 0;
    int   cur_id   = 0;
    int   last_id  = -1;
    int   jj       = 0;
    logic tie1     = 1'b0;
    logic hist[64];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model of acceptance
    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
        if (!rst_n) begin
            q.delete();
            next_free = cyc + 1;
        end else if (start && cyc >= next_free) begin
            exp_t e;
            e.din    = din;
            e.dout   = tie1 ? {DATA_W{1'b1}} : din;
`ifdef DAISY_LOOPBACK_CHECK_EN
            e.mm     = (e.dout != din);
`else
            e.mm     = 1'b0;
`endif
            e.t_done = cyc + LAT;
            q.push_back(e);
            cur_id    = cur_id + 1;
            next_free = cyc + LAT + 2;
        end
    end

    // Slave chain: records mosi at each sclk falling edge, returns it DELAY
    // falling edges later.
    initial forever begin
        @(negedge sclk);
        if (last_id != cur_id) begin
            last_id = cur_id;
            jj = 0;
        end
        if (jj < 64) hist[jj] = mosi;
        jj = jj + 1;
    end

    always_comb begin
        miso = 1'b0;
        if (tie1) miso = 1'b1;
        else if (last_id == cur_id && jj >= DELAY && jj - DELAY < 64) miso = hist[jj - DELAY];
    end

    // Monitor
    initial forever begin
        @(negedge clk);
        if (rst_n && done) begin
            if (q.size() == 0) begin
                chk("unexpected_done", 64'(done), 64'(0));
            end else begin
                exp_t e;
                logic [63:0] mv;
                e = q.pop_front();
                mv = '0;
                for (int i = 0; i < N_PER && i < 64; i++) mv[i] = hist[i];
                chk("dout", 64'(dout), 64'(e.dout));
                chk("mismatch", 64'(mismatch), 64'(e.mm));
                chk("done_time", 64'(cyc), 64'(e.t_done));
                chk("sclk_periods", 64'(jj), 64'(N_PER));
                chk("mosi_seq", mv, 64'(e.din));
                chk("cs_busy_in_done", 64'({cs, newd, busy}), 64'(3'b101));
            end
        end
    end

    task automatic check_reset_state(input string name);
        chk(name, 64'({sclk, cs, newd, mosi, busy, done, mismatch}), 64'(7'b0100000));
        chk({name, "_dout"}, 64'(dout), 64'(0));
    endtask

    // Drives one transfer and waits until the DUT is idle again. If ign_at
    // is nonzero a start with din=0xFF is pulsed that many cycles in.
    task automatic xfer(input logic [DATA_W-1:0] d, input logic t1, input int ign_at);
        din   = d;
        tie1  = t1;
        start = 1'b1;
        for (int i = 0; i <= LAT + 1; i++) begin
            @(negedge clk);
            start = (i + 1 == ign_at);
            if (i + 1 == ign_at) din = 8'hFF;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        din   = '0;
        repeat (3) @(negedge clk);
        check_reset_state("reset_state");
        rst_n = 1'b1;
        @(negedge clk);

        xfer(8'hA5, 1'b0, 0);
        xfer(8'h3C, 1'b0, 0);
        xfer(8'h00, 1'b1, 0);
        xfer(8'h5A, 1'b0, 20);

        for (int k = 0; k < 8; k++) begin
            xfer(DATA_W'($urandom), ($urandom_range(0, 3) == 0), 0);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        // Reset in the middle of a transfer
        din   = 8'h5A;
        tie1  = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (48) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_state("mid_reset");
        rst_n = 1'b1;
        @(negedge clk);
        xfer(8'h81, 1'b0, 0);

        // Back-to-back with start held high
        din   = 8'h11;
        start = 1'b1;
        @(negedge clk);
        din = 8'h22;
        repeat (LAT + 2) @(negedge clk);
        start = 1'b0;
        repeat (LAT + 2) @(negedge clk);

        repeat (5) @(negedge clk);
        chk("pending_transfers", 64'(q.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
